rc4_compute: RTL and testbench
==============================

# rc4_compute

RC4 keystream-generation (PRGA) stage of the decrypt pipeline. Runs after the key-schedule (shuffle) stage has left the 256-byte S array permuted in S memory. It walks MSG_LEN message bytes, swaps S entries, XORs each keystream byte with the encrypted ROM byte, and writes the plaintext to the result RAM. The decrypt sequencer starts it, owns the S-memory mux, and waits on its completion flag.

## Interface
- MSG_LEN, 32: message length in bytes; 1..2**ADDR_W
- ADDR_W, 5: ROM/result-RAM address width

- clk  in  1  sole clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- compute_start  in  1  level request from sequencer, held high for the whole stage
- compute_complete  out  1  high only in DONE
- address_compute  out  8  S-memory address
- data_compute  out  8  S-memory write data
- wren_compute  out  1  S-memory write enable
- s_q  in  8  S-memory read data
- rom_address  out  ADDR_W  encrypted-message ROM address
- rom_q  in  8  ROM read data
- ram_address  out  ADDR_W  result RAM address
- ram_data  out  8  result RAM write data
- ram_wren  out  1  result RAM write enable

## Operation
- Registers: i, j (8 b), si, sj, f (8 b), k (ADDR_W b). All arithmetic on i, j and si+sj is mod 256, with carry discarded.
- IDLE: when compute_start=1, clear i, j and k, then go to RD_SI.
- RD_SI: address=i+1; i<=i+1.
- CAP_SI: si<=s_q; j<=j+s_q.
- RD_SJ: address=j.
- CAP_SJ: sj<=s_q.
- WR_SI: address=i, data=sj, wren=1.
- WR_SJ: address=j, data=si, wren=1.
- RD_F: address=si+sj, using the pre-swap registered values.
- CAP_F: f<=s_q.
- WR_OUT: ram_address=k, ram_data=f^rom_q, ram_wren=1; k<=k+1.
  - If k==MSG_LEN-1, go to DONE; otherwise go to RD_SI.
- DONE: compute_complete=1. Stay in DONE while compute_start=1; go to IDLE when it drops.
- rom_address=k continuously. k changes only at the end of WR_OUT, so rom_q is stable long before the next WR_OUT.
- Outputs are combinational from state plus registers. In every state not listed above:
  - address_compute=0, data_compute=0
  - all wren=0
  - ram_address=0, ram_data=0
- i==j: the two swap writes hit the same address with equal data. No special case.
- compute_start falling in any state other than IDLE/DONE: abort to IDLE on the next edge. No further writes occur.
- reset_n low at any time: immediately go to IDLE. All registers and all outputs are 0, including compute_complete=0.

## Timing
- S memory and ROM have 1-cycle read latency. An address driven in cycle N gives q valid during N+1, which the CAP_*/WR_OUT state samples.
- 9 cycles per byte. If compute_start is first sampled high in cycle 0:
  - the first S write occurs in cycle 5;
  - the first RAM write occurs in cycle 9;
  - compute_complete rises in cycle 1+9*MSG_LEN.
- Writes are single-cycle pulses. There is exactly one ram_wren pulse per byte, and exactly two wren_compute pulses per byte.
- No output is asserted in the cycle compute_start is first sampled.

## Structure
- rc4_pkg holds the state enum, MSG_LEN/ADDR_W defaults and the S-memory width constant. The init and shuffle stages share it.
- Single module with no sub-module. The FSM and datapath together are about 150 lines.

## Test plan
- Identity S (s[x]=x), ROM all 0x00, MSG_LEN=4:
  - RAM receives 0x02, 0x05, 0x07, 0x0D at addresses 0-3.
  - compute_complete rises in cycle 37.
- Same setup, ROM = 0xFF×4: RAM receives 0xFD, 0xFA, 0xF8, 0xF2.
- Identity S, check the first byte's swap (i=j=1): S-memory writes at cycles 5 and 6 both go to addr 1 with data 0x01. S is otherwise unchanged at the first WR_OUT.
- Hold compute_start after DONE for 10 cycles:
  - compute_complete stays 1 with no writes;
  - after compute_start drops, the block returns to IDLE, and a second start reproduces the same first output for the same S/ROM.
- Assert reset_n=0 in CAP_SJ of byte 2: all outputs read 0 in the same cycle, with no further writes. After release, the state is IDLE.
- Drop compute_start in RD_F: the block returns to IDLE the next cycle, with no ram_wren for that byte and compute_complete never asserted.

Source files
------------

// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and defaults for the RC4 decrypt stages
package rc4_pkg;

    // Width of one S-memory entry and of its address (256 entries).
    localparam int S_W = 8;

    // Defaults for the message being decrypted.
    localparam int MSG_LEN_DEF = 32;
    localparam int ADDR_W_DEF  = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_SI,
        ST_CAP_SI,
        ST_RD_SJ,
        ST_CAP_SJ,
        ST_WR_SI,
        ST_WR_SJ,
        ST_RD_F,
        ST_CAP_F,
        ST_WR_OUT,
        ST_DONE
    } rc4_state_e;

endpackage

// File: rtl/rc4_compute.sv
// rtl/rc4_compute.sv - RC4 keystream generation and XOR decrypt into result RAM
//
// Walks MSG_LEN bytes: swaps S[i]/S[j], reads S[S[i]+S[j]] and writes
// keystream ^ ROM byte into the result RAM. 9 cycles per byte.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   compute_start         level request, held high for the whole stage
//   compute_complete      high while in DONE
//   address_compute/data_compute/wren_compute/s_q   S-memory port
//   rom_address/rom_q     encrypted-message ROM port
//   ram_address/ram_data/ram_wren                   result RAM write port
module rc4_compute
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              compute_start,
    output logic              compute_complete,
    output logic [S_W-1:0]    address_compute,
    output logic [S_W-1:0]    data_compute,
    output logic              wren_compute,
    input  logic [S_W-1:0]    s_q,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [S_W-1:0]    rom_q,
    output logic [ADDR_W-1:0] ram_address,
    output logic [S_W-1:0]    ram_data,
    output logic              ram_wren
);

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(MSG_LEN - 1);

    rc4_state_e     state, state_nxt;
    logic [S_W-1:0] i, j, si, sj, f;
    logic [ADDR_W-1:0] k;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            i     <= '0;
            j     <= '0;
            si    <= '0;
            sj    <= '0;
            f     <= '0;
            k     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (compute_start) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end
                end
                ST_RD_SI:  i  <= i + 1'b1;
                ST_CAP_SI: begin
                    si <= s_q;
                    j  <= j + s_q;
                end
                ST_CAP_SJ: sj <= s_q;
                ST_CAP_F:  f  <= s_q;
                ST_WR_OUT: k  <= k + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (compute_start) state_nxt = ST_RD_SI;
            ST_DONE: if (!compute_start) state_nxt = ST_IDLE;
            default: begin
                // Dropping the request mid-byte abandons the stage.
                if (!compute_start) begin
                    state_nxt = ST_IDLE;
                end else begin
                    case (state)
                        ST_RD_SI:  state_nxt = ST_CAP_SI;
                        ST_CAP_SI: state_nxt = ST_RD_SJ;
                        ST_RD_SJ:  state_nxt = ST_CAP_SJ;
                        ST_CAP_SJ: state_nxt = ST_WR_SI;
                        ST_WR_SI:  state_nxt = ST_WR_SJ;
                        ST_WR_SJ:  state_nxt = ST_RD_F;
                        ST_RD_F:   state_nxt = ST_CAP_F;
                        ST_CAP_F:  state_nxt = ST_WR_OUT;
                        ST_WR_OUT: state_nxt = (k == K_LAST) ? ST_DONE : ST_RD_SI;
                        default:   state_nxt = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    // k only moves at the end of WR_OUT, so the ROM read has settled well
    // before the next WR_OUT samples rom_q.
    assign rom_address = k;

    always_comb begin
        address_compute  = '0;
        data_compute     = '0;
        wren_compute     = 1'b0;
        ram_address      = '0;
        ram_data         = '0;
        ram_wren         = 1'b0;
        compute_complete = 1'b0;
        case (state)
            ST_RD_SI: address_compute = i + 1'b1;
            ST_RD_SJ: address_compute = j;
            ST_WR_SI: begin
                address_compute = i;
                data_compute    = sj;
                wren_compute    = 1'b1;
            end
            ST_WR_SJ: begin
                address_compute = j;
                data_compute    = si;
                wren_compute    = 1'b1;
            end
            // si/sj still hold the values read before the swap.
            ST_RD_F: address_compute = si + sj;
            ST_WR_OUT: begin
                ram_address = k;
                ram_data    = f ^ rom_q;
                ram_wren    = 1'b1;
            end
            ST_DONE: compute_complete = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_compute.sv
// tb/tb_rc4_compute.sv - directed self-checking bench for rc4_compute
module tb_rc4_compute;

    localparam int MSG_LEN = 4;
    localparam int ADDR_W  = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              compute_start;
    logic              compute_complete;
    logic [7:0]        address_compute;
    logic [7:0]        data_compute;
    logic              wren_compute;
    logic [7:0]        s_q;
    logic [ADDR_W-1:0] rom_address;
    logic [7:0]        rom_q;
    logic [ADDR_W-1:0] ram_address;
    logic [7:0]        ram_data;
    logic              ram_wren;

    always #5 clk = ~clk;

    rc4_compute #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .compute_start    (compute_start),
        .compute_complete (compute_complete),
        .address_compute  (address_compute),
        .data_compute     (data_compute),
        .wren_compute     (wren_compute),
        .s_q              (s_q),
        .rom_address      (rom_address),
        .rom_q            (rom_q),
        .ram_address      (ram_address),
        .ram_data         (ram_data),
        .ram_wren         (ram_wren)
    );

    // S memory and ROM with 1-cycle read latency.
    logic [7:0] smem [256];
    logic [7:0] rom  [32];
    logic       load_id;

    always @(posedge clk) begin
        if (load_id) begin
            for (int x = 0; x < 256; x++) smem[x] <= 8'(x);
        end else if (wren_compute) begin
            smem[address_compute] <= data_compute;
        end
        s_q   <= smem[address_compute];
        rom_q <= rom[rom_address];
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    logic [7:0] ram_got [32];
    int         ram_cnt, first_ram_cyc, done_cyc, s_wr_cnt, s_diff, hold_bad;
    int         sw_cyc  [2];
    logic [7:0] sw_addr [2];
    logic [7:0] sw_data [2];
    logic [7:0] rd_f_addr;

    task automatic fill_rom(input logic [7:0] v);
        for (int x = 0; x < 32; x++) rom[x] = v;
    endtask

    task automatic load_identity();
        @(negedge clk);
        load_id = 1'b1;
        @(negedge clk);
        load_id = 1'b0;
    endtask

    // Raises compute_start in cycle 0 and observes each later cycle mid-period.
    task automatic run_stage(input int limit, input int drop_at);
        ram_cnt = 0; first_ram_cyc = -1; done_cyc = -1; s_wr_cnt = 0; s_diff = -1;
        rd_f_addr = 8'hEE;
        for (int x = 0; x < 32; x++) ram_got[x] = 8'h00;
        for (int x = 0; x < 2; x++) begin
            sw_cyc[x] = -1; sw_addr[x] = 8'hEE; sw_data[x] = 8'hEE;
        end
        @(negedge clk);
        compute_start = 1'b1;
        #1;
        check("cycle0_quiet", {29'd0, wren_compute, ram_wren, compute_complete}, 32'd0);
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            if (cyc == 7) rd_f_addr = address_compute;
            if (cyc == drop_at) compute_start = 1'b0;
            if (wren_compute) begin
                if (s_wr_cnt < 2) begin
                    sw_cyc[s_wr_cnt]  = cyc;
                    sw_addr[s_wr_cnt] = address_compute;
                    sw_data[s_wr_cnt] = data_compute;
                end
                s_wr_cnt++;
            end
            if (ram_wren) begin
                if (ram_cnt == 0) begin
                    first_ram_cyc = cyc;
                    s_diff = 0;
                    for (int x = 0; x < 256; x++) if (smem[x] !== 8'(x)) s_diff++;
                end
                ram_got[ram_address] = ram_data;
                ram_cnt++;
            end
            if (compute_complete) begin
                done_cyc = cyc;
                break;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        compute_start = 1'b0;
        load_id = 1'b0;
        fill_rom(8'h00);
        repeat (3) @(negedge clk);

        check("rst_s_port", {15'd0, address_compute, data_compute, wren_compute}, 32'd0);
        check("rst_ram_port", {13'd0, compute_complete, rom_address, ram_address, ram_data, ram_wren}, 32'd0);

        reset_n = 1'b1;
        load_identity();
        run_stage(60, -1);
        check("run1_done_cycle", done_cyc, 37);
        check("run1_ram_count", ram_cnt, 4);
        check("run1_b0", ram_got[0], 8'h02);
        check("run1_b1", ram_got[1], 8'h05);
        check("run1_b2", ram_got[2], 8'h07);
        check("run1_b3", ram_got[3], 8'h0D);
        check("run1_first_ram_cyc", first_ram_cyc, 9);
        check("swap_w0_cyc", sw_cyc[0], 5);
        check("swap_w1_cyc", sw_cyc[1], 6);
        check("swap_w0", {sw_addr[0], sw_data[0]}, 16'h0101);
        check("swap_w1", {sw_addr[1], sw_data[1]}, 16'h0101);
        check("run1_s_writes", s_wr_cnt, 8);
        check("s_unchanged_first_out", s_diff, 0);
        check("run1_rd_f_addr", rd_f_addr, 8'h02);

        hold_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!compute_complete || wren_compute || ram_wren) hold_bad++;
        end
        check("done_hold", hold_bad, 0);
        compute_start = 1'b0;
        @(negedge clk);
        check("done_release", compute_complete, 1'b0);

        load_identity();
        fill_rom(8'hFF);
        run_stage(60, -1);
        check("run2_done_cycle", done_cyc, 37);
        check("run2_b0", ram_got[0], 8'hFD);
        check("run2_b1", ram_got[1], 8'hFA);
        check("run2_b2", ram_got[2], 8'hF8);
        check("run2_b3", ram_got[3], 8'hF2);

        // Reset in CAP_SJ of byte 2 (cycle 13).
        compute_start = 1'b0;
        load_identity();
        fill_rom(8'h00);
        @(negedge clk);
        compute_start = 1'b1;
        repeat (13) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_s_port", {15'd0, address_compute, data_compute, wren_compute}, 32'd0);
        check("rst_mid_ram_port", {13'd0, compute_complete, rom_address, ram_address, ram_data, ram_wren}, 32'd0);
        hold_bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (wren_compute || ram_wren || compute_complete) hold_bad++;
        end
        compute_start = 1'b0;
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (wren_compute || ram_wren || compute_complete) hold_bad++;
        end
        check("rst_mid_quiet", hold_bad, 0);
        load_identity();
        run_stage(60, -1);
        check("after_rst_b0", ram_got[0], 8'h02);
        check("after_rst_done", done_cyc, 37);
        compute_start = 1'b0;
        @(negedge clk);

        // Drop compute_start in RD_F of byte 1 (cycle 7).
        load_identity();
        run_stage(30, 7);
        check("abort_rd_f_addr", rd_f_addr, 8'h02);
        check("abort_ram_count", ram_cnt, 0);
        check("abort_never_done", done_cyc, -1);
        check("abort_s_writes", s_wr_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
